// File: rtl/ring_phase_monitor_if.sv
// Bus between the ring counter / control side and ring_phase_monitor.
// The master drives the ring sample and controls; the monitor (slave) returns phase and health status.
interface ring_phase_monitor_if #(
  parameter int N  = 4,
  parameter int RW = 8,
  parameter int IW = $clog2(N)
) ();
  logic [N-1:0]  ring_in;
  logic          adv;
  logic          clr_err;
  logic [IW-1:0] phase_idx;
  logic          phase_vld;
  logic          locked;
  logic          rev_pulse;
  logic [RW-1:0] rev_cnt;
  logic          illegal_err;
  logic          skip_err;
  logic [7:0]    err_cnt;

  modport master (
    output ring_in, adv, clr_err,
    input  phase_idx, phase_vld, locked, rev_pulse, rev_cnt,
           illegal_err, skip_err, err_cnt
  );

  modport slave (
    input  ring_in, adv, clr_err,
    output phase_idx, phase_vld, locked, rev_pulse, rev_cnt,
           illegal_err, skip_err, err_cnt
  );
endinterface

// File: rtl/ring_phase_monitor.sv
// Checks a rotate-right one-hot ring for legality and single-step advance,
// encodes it to a phase index, counts revolutions and records errors.
module ring_phase_monitor #(
  parameter int N  = 4,
  parameter int RW = 8,
  parameter int IW = $clog2(N)
) (
  input logic clk,
  input logic rst,
  ring_phase_monitor_if.slave bus
);

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t        state_reg;
  logic [N-1:0]  prev_reg;
  logic [IW-1:0] phase_idx_reg;
  logic          phase_vld_reg;
  logic          rev_pulse_reg;
  logic [RW-1:0] rev_cnt_reg;
  logic          illegal_err_reg;
  logic          skip_err_reg;
  logic [7:0]    err_cnt_reg;

  logic [N-1:0]  expected;
  logic          onehot;
  logic          match;
  logic          wrap;
  logic [IW-1:0] idx_enc;
  logic [7:0]    err_cnt_base;
  logic [7:0]    err_cnt_next;

  // Binary encoder: index bit gi is the OR of every ring bit whose position has bit gi set.
  logic [N-1:0] enc_sel [IW];
  generate
    for (genvar gi = 0; gi < IW; gi++) begin : g_enc_bit
      for (genvar gj = 0; gj < N; gj++) begin : g_enc_src
        if (((gj >> gi) & 1) == 1) begin : g_use
          assign enc_sel[gi][gj] = bus.ring_in[gj];
        end else begin : g_skip
          assign enc_sel[gi][gj] = 1'b0;
        end
      end
      assign idx_enc[gi] = |enc_sel[gi];
    end
  endgenerate

  always_comb begin
    expected     = {prev_reg[0], prev_reg[N-1:1]};
    onehot       = (bus.ring_in != '0) && ((bus.ring_in & (bus.ring_in - 1'b1)) == '0);
    match        = (bus.ring_in == expected);
    wrap         = prev_reg[1] && bus.ring_in[0];
    // A clear in the same cycle as an error restarts the count at that error.
    err_cnt_base = bus.clr_err ? 8'd0 : err_cnt_reg;
    err_cnt_next = (err_cnt_base == 8'd255) ? err_cnt_base : err_cnt_base + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= UNLOCKED;
      prev_reg        <= '0;
      phase_idx_reg   <= '0;
      phase_vld_reg   <= 1'b0;
      rev_pulse_reg   <= 1'b0;
      rev_cnt_reg     <= '0;
      illegal_err_reg <= 1'b0;
      skip_err_reg    <= 1'b0;
      err_cnt_reg     <= 8'd0;
    end else begin
      rev_pulse_reg <= 1'b0;
      if (bus.clr_err) begin
        illegal_err_reg <= 1'b0;
        skip_err_reg    <= 1'b0;
        err_cnt_reg     <= 8'd0;
      end
      if (bus.adv) begin
        case (state_reg)
          UNLOCKED: begin
            if (onehot) begin
              prev_reg      <= bus.ring_in;
              phase_idx_reg <= idx_enc;
              phase_vld_reg <= 1'b1;
              state_reg     <= LOCKED;
            end else begin
              illegal_err_reg <= 1'b1;
              err_cnt_reg     <= err_cnt_next;
            end
          end
          LOCKED: begin
            if (match) begin
              prev_reg      <= bus.ring_in;
              phase_idx_reg <= idx_enc;
              if (wrap) begin
                rev_pulse_reg <= 1'b1;
                rev_cnt_reg   <= rev_cnt_reg + 1'b1;
              end
            end else if (onehot) begin
              // Out-of-sequence but legal: resynchronise on this sample without counting a revolution.
              skip_err_reg  <= 1'b1;
              err_cnt_reg   <= err_cnt_next;
              prev_reg      <= bus.ring_in;
              phase_idx_reg <= idx_enc;
            end else begin
              illegal_err_reg <= 1'b1;
              err_cnt_reg     <= err_cnt_next;
              phase_vld_reg   <= 1'b0;
              state_reg       <= UNLOCKED;
            end
          end
          default: state_reg <= UNLOCKED;
        endcase
      end
    end
  end

  assign bus.phase_idx   = phase_idx_reg;
  assign bus.phase_vld   = phase_vld_reg;
  assign bus.locked      = (state_reg == LOCKED);
  assign bus.rev_pulse   = rev_pulse_reg;
  assign bus.rev_cnt     = rev_cnt_reg;
  assign bus.illegal_err = illegal_err_reg;
  assign bus.skip_err    = skip_err_reg;
  assign bus.err_cnt     = err_cnt_reg;

endmodule
